// File: rtl/pea_dispatch_pkg.sv
// Shared definitions for the polynomial-evaluation firing controller:
// FSM state encoding, error status words and firing mode values.
package pea_dispatch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_FETCH_WAIT,
        ST_DISPATCH,
        ST_RUN,
        ST_ERR,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [15:0] STATUS_ILLEGAL = 16'hFFFF;
    localparam logic [15:0] STATUS_TIMEOUT = 16'hFFFE;

    localparam logic MODE_FETCH = 1'b0;
    localparam logic MODE_EXEC  = 1'b1;

endpackage

// File: rtl/firing_dispatch_fsm_if.sv
// Signal bundle between the firing controller and its neighbours: parent
// scheduler, command-fetch unit, instruction engines and output FIFO.
interface firing_dispatch_fsm_if #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_ENG   = 4,
    parameter int OPC_W     = 8
);
    logic                          start;
    logic                          mode;
    logic                          fetch_start;
    logic                          fetch_done;
    logic [OPC_W-1:0]              opcode;
    logic [2:0]                    arg1;
    logic [4:0]                    arg2;
    logic [2:0]                    arg1_q;
    logic [4:0]                    arg2_q;
    logic [NUM_ENG-1:0]            eng_start;
    logic [NUM_ENG-1:0]            eng_abort;
    logic                          eng_hold;
    logic [NUM_ENG-1:0]            eng_emit;
    logic [NUM_ENG-1:0]            eng_done;
    logic [NUM_ENG*WORD_SIZE-1:0]  eng_result;
    logic [NUM_ENG*WORD_SIZE-1:0]  eng_status;
    logic                          out_full;
    logic                          out_wr_en;
    logic [WORD_SIZE-1:0]          out_result;
    logic [WORD_SIZE-1:0]          out_status;
    logic                          done;
    logic                          busy;
    logic                          err_ovf;

    // The controller side.
    modport master (
        input  start, mode, fetch_done, opcode, arg1, arg2,
               eng_emit, eng_done, eng_result, eng_status, out_full,
        output fetch_start, arg1_q, arg2_q, eng_start, eng_abort, eng_hold,
               out_wr_en, out_result, out_status, done, busy, err_ovf
    );

    // The environment side.
    modport slave (
        output start, mode, fetch_done, opcode, arg1, arg2,
               eng_emit, eng_done, eng_result, eng_status, out_full,
        input  fetch_start, arg1_q, arg2_q, eng_start, eng_abort, eng_hold,
               out_wr_en, out_result, out_status, done, busy, err_ovf
    );

endinterface

// File: rtl/result_hold_reg.sv
// Single-entry result buffer in front of the output FIFO. Tracks the sticky
// overflow flag for intermediate words that arrive while the entry is stalled.
module result_hold_reg #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_dropIfStalled,
    input  logic [WORD_SIZE-1:0] i_result,
    input  logic [WORD_SIZE-1:0] i_status,
    input  logic                 i_outFull,
    output logic                 o_outWrEn,
    output logic [WORD_SIZE-1:0] o_outResult,
    output logic [WORD_SIZE-1:0] o_outStatus,
    output logic                 o_engHold,
    output logic                 o_errOvf
);
    logic                 r_valid;
    logic [WORD_SIZE-1:0] r_result;
    logic [WORD_SIZE-1:0] r_status;
    logic                 r_errOvf;
    logic                 w_write;
    logic                 w_drop;

    assign w_write = r_valid & ~i_outFull;
    // An emit is only lost when the entry is full and not leaving this cycle.
    assign w_drop  = i_load & i_dropIfStalled & r_valid & ~w_write;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_status <= '0;
            r_errOvf <= 1'b0;
        end else begin
            if (i_load && !w_drop) begin
                r_valid  <= 1'b1;
                r_result <= i_result;
                r_status <= i_status;
            end else if (w_write) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_errOvf <= 1'b1;
            end
        end
    end

    assign o_outWrEn   = w_write;
    assign o_outResult = r_result;
    assign o_outStatus = r_status;
    assign o_engHold   = r_valid & ~w_write;
    assign o_errOvf    = r_errOvf;

endmodule

// File: rtl/firing_dispatch_fsm.sv
// Firing controller: per firing either fetches one instruction or dispatches the
// latched one to its engine, guarding the run with a watchdog and draining results.
module firing_dispatch_fsm
    import pea_dispatch_pkg::*;
#(
    parameter int                 WORD_SIZE = 16,
    parameter int                 NUM_ENG   = 4,
    parameter int                 OPC_W     = 8,
    parameter int                 TIMEOUT   = 1024,
    parameter logic [NUM_ENG-1:0] OUT_MASK  = 4'b0111
) (
    input logic                   clk,
    input logic                   rst,
    firing_dispatch_fsm_if.master bus
);
    localparam int                SEL_W     = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int                TMR_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [31:0]       NUM_ENG_U = 32'(NUM_ENG);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

    state_t               r_state;
    logic [OPC_W-1:0]     r_opcodeQ;
    logic [2:0]           r_arg1Q;
    logic [4:0]           r_arg2Q;
    logic                 r_fetchStart;
    logic [NUM_ENG-1:0]   r_engStart;
    logic [NUM_ENG-1:0]   r_engAbort;
    logic                 r_done;
    logic [TMR_W-1:0]     r_timer;
    logic [WORD_SIZE-1:0] r_errStatus;

    logic [SEL_W-1:0]     w_sel;
    logic                 w_legal;
    logic [NUM_ENG-1:0]   w_selOneHot;
    logic                 w_selDone;
    logic                 w_selEmit;
    logic [WORD_SIZE-1:0] w_selResult;
    logic [WORD_SIZE-1:0] w_selStatus;
    logic                 w_load;
    logic                 w_dropIfStalled;
    logic [WORD_SIZE-1:0] w_loadResult;
    logic [WORD_SIZE-1:0] w_loadStatus;
    logic                 w_engHold;

    // Opcode legality is an unsigned compare over the full opcode width.
    assign w_legal     = ({{(32 - OPC_W){1'b0}}, r_opcodeQ} < NUM_ENG_U);
    assign w_sel       = r_opcodeQ[SEL_W-1:0];
    assign w_selDone   = bus.eng_done[w_sel];
    assign w_selEmit   = bus.eng_emit[w_sel];
    assign w_selResult = bus.eng_result[int'(w_sel) * WORD_SIZE +: WORD_SIZE];
    assign w_selStatus = bus.eng_status[int'(w_sel) * WORD_SIZE +: WORD_SIZE];

    always_comb begin
        w_selOneHot        = '0;
        w_selOneHot[w_sel] = 1'b1;
    end

    // Decides what enters the hold register; a done in the same cycle as an
    // emit counts as the single final word and is never dropped.
    always_comb begin
        w_load          = 1'b0;
        w_dropIfStalled = 1'b0;
        w_loadResult    = w_selResult;
        w_loadStatus    = w_selStatus;
        case (r_state)
            ST_RUN: begin
                if (w_selDone) begin
                    w_load = OUT_MASK[w_sel];
                end else if (w_selEmit) begin
                    w_load          = 1'b1;
                    w_dropIfStalled = 1'b1;
                end
            end
            ST_ERR: begin
                if (!w_engHold) begin
                    w_load       = 1'b1;
                    w_loadResult = '0;
                    w_loadStatus = r_errStatus;
                end
            end
            default: begin
            end
        endcase
    end

    result_hold_reg #(
        .WORD_SIZE (WORD_SIZE)
    ) u_hold (
        .clk             (clk),
        .rst             (rst),
        .i_load          (w_load),
        .i_dropIfStalled (w_dropIfStalled),
        .i_result        (w_loadResult),
        .i_status        (w_loadStatus),
        .i_outFull       (bus.out_full),
        .o_outWrEn       (bus.out_wr_en),
        .o_outResult     (bus.out_result),
        .o_outStatus     (bus.out_status),
        .o_engHold       (w_engHold),
        .o_errOvf        (bus.err_ovf)
    );

    // Pulses are set on the transition into a state so each appears one cycle
    // after the event that caused it; eng_start is decided already in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_opcodeQ    <= '0;
            r_arg1Q      <= '0;
            r_arg2Q      <= '0;
            r_fetchStart <= 1'b0;
            r_engStart   <= '0;
            r_engAbort   <= '0;
            r_done       <= 1'b0;
            r_timer      <= '0;
            r_errStatus  <= '0;
        end else begin
            r_fetchStart <= 1'b0;
            r_engStart   <= '0;
            r_engAbort   <= '0;
            r_done       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.mode == MODE_EXEC) begin
                            r_state <= ST_DISPATCH;
                            if (w_legal) begin
                                r_engStart <= w_selOneHot;
                            end
                        end else begin
                            r_state      <= ST_FETCH;
                            r_fetchStart <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_FETCH_WAIT;
                end
                ST_FETCH_WAIT: begin
                    if (bus.fetch_done) begin
                        r_opcodeQ <= bus.opcode;
                        r_arg1Q   <= bus.arg1;
                        r_arg2Q   <= bus.arg2;
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                    end
                end
                ST_DISPATCH: begin
                    if (!w_legal) begin
                        r_errStatus <= WORD_SIZE'(STATUS_ILLEGAL);
                        r_state     <= ST_ERR;
                    end else begin
                        r_timer <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (r_timer != {TMR_W{1'b1}}) begin
                        r_timer <= r_timer + 1'b1;
                    end
                    if (w_selDone) begin
                        if (OUT_MASK[w_sel] || w_engHold) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end else if (TIMEOUT != 0 && r_timer == TMR_LAST) begin
                        r_engAbort  <= w_selOneHot;
                        r_errStatus <= WORD_SIZE'(STATUS_TIMEOUT);
                        r_state     <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    if (!w_engHold) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!w_engHold) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.fetch_start = r_fetchStart;
    assign bus.arg1_q      = r_arg1Q;
    assign bus.arg2_q      = r_arg2Q;
    assign bus.eng_start   = r_engStart;
    assign bus.eng_abort   = r_engAbort;
    assign bus.eng_hold    = w_engHold;
    assign bus.done        = r_done;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_firing_dispatch_fsm.sv
// Bench for the firing controller: scripted engine behaviour per scenario, with
// expected output-FIFO words queued at stimulus time and matched on each write.
module tb_firing_dispatch_fsm;
    import pea_dispatch_pkg::*;

    localparam int WS = 16;
    localparam int NE = 4;
    localparam int OW = 8;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          errors = 0;
    int          checks = 0;
    int          wrCount = 0;
    logic [31:0] sbQ[$];

    firing_dispatch_fsm_if #(.WORD_SIZE(WS), .NUM_ENG(NE), .OPC_W(OW)) bus ();

    firing_dispatch_fsm #(
        .WORD_SIZE (WS),
        .NUM_ENG   (NE),
        .OPC_W     (OW),
        .TIMEOUT   (TO),
        .OUT_MASK  (4'b0111)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Every FIFO write must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst && bus.out_wr_en) begin
            logic [31:0] exp;
            wrCount++;
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got %h_%h, none expected", bus.out_result, bus.out_status);
            end else begin
                exp = sbQ.pop_front();
                if ({bus.out_result, bus.out_status} !== exp) begin
                    errors++;
                    $display("[TB] FAIL write_data: got %h_%h expected %h", bus.out_result, bus.out_status, exp);
                end
            end
            checks++;
            if (bus.out_full !== 1'b0) begin
                errors++;
                $display("[TB] FAIL backpressure: out_wr_en while out_full=%b, required 0", bus.out_full);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        bus.start      = 1'b0;
        bus.mode       = MODE_FETCH;
        bus.fetch_done = 1'b0;
        bus.opcode     = '0;
        bus.arg1       = '0;
        bus.arg2       = '0;
        bus.eng_emit   = '0;
        bus.eng_done   = '0;
        bus.eng_result = {$urandom, $urandom};
        bus.eng_status = {$urandom, $urandom};
        bus.out_full   = 1'b0;
    endtask

    task automatic startExec();
        bus.mode  = MODE_EXEC;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b0;
        #23;
        checks++;
        if ({bus.fetch_start, bus.eng_start, bus.eng_abort, bus.eng_hold, bus.out_wr_en,
             bus.done, bus.busy, bus.err_ovf} !== 14'h0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b, required all 0",
                     {bus.fetch_start, bus.eng_start, bus.eng_abort, bus.eng_hold, bus.out_wr_en,
                      bus.done, bus.busy, bus.err_ovf});
        end
        checks++;
        if ({bus.arg1_q, bus.arg2_q, bus.out_result, bus.out_status} !== 40'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h, required 0",
                     {bus.arg1_q, bus.arg2_q, bus.out_result, bus.out_status});
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy=%b, required 0", bus.busy);
        end
    endtask

    task automatic test_fetch(input logic [7:0] opc, input logic [2:0] a1, input logic [4:0] a2);
        bus.mode  = MODE_FETCH;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.fetch_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_start: got %b required 1", bus.fetch_start);
        end
        tick();
        checks++;
        if (bus.fetch_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fetch_start_pulse: got %b required 0", bus.fetch_start);
        end
        tick();
        bus.fetch_done = 1'b1;
        bus.opcode     = opc;
        bus.arg1       = a1;
        bus.arg2       = a2;
        tick();
        bus.fetch_done = 1'b0;
        bus.opcode     = 8'hA5;
        bus.arg1       = ~a1;
        bus.arg2       = ~a2;
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fetch_done: done=%b required 1", bus.done);
        end
        checks++;
        if ({bus.arg1_q, bus.arg2_q} !== {a1, a2}) begin
            errors++;
            $display("[TB] FAIL fetch_args: got %h/%h required %h/%h", bus.arg1_q, bus.arg2_q, a1, a2);
        end
        tick();
        checks++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL fetch_idle: done/busy=%b required 00", {bus.done, bus.busy});
        end
    endtask

    task automatic test_evp();
        int w0 = wrCount;
        startExec();
        checks++;
        if (bus.eng_start !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL evp_start: got %b required 0010", bus.eng_start);
        end
        tick();
        checks++;
        if (bus.eng_start !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL evp_start_pulse: got %b required 0000", bus.eng_start);
        end
        // Foreign engine activity and a stray start must both be ignored.
        bus.eng_done[0] = 1'b1;
        bus.eng_emit[2] = 1'b1;
        bus.mode        = MODE_FETCH;
        bus.start       = 1'b1;
        tick();
        bus.eng_done = '0;
        bus.eng_emit = '0;
        bus.start    = 1'b0;
        checks++;
        if ({bus.busy, bus.fetch_start, bus.eng_start} !== 6'b100000) begin
            errors++;
            $display("[TB] FAIL evp_ignore: busy/fetch/start=%b required 100000",
                     {bus.busy, bus.fetch_start, bus.eng_start});
        end
        repeat (4) tick();
        bus.eng_result[16 +: 16] = 16'h0042;
        bus.eng_status[16 +: 16] = 16'h0000;
        bus.eng_done[1]          = 1'b1;
        sbQ.push_back({16'h0042, 16'h0000});
        tick();
        bus.eng_done = '0;
        checks++;
        if (bus.out_wr_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL evp_wr_latency: out_wr_en=%b required 1", bus.out_wr_en);
        end
        tick();
        checks++;
        if ({bus.done, bus.out_wr_en} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL evp_done: done/wr=%b required 10", {bus.done, bus.out_wr_en});
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || wrCount - w0 != 1) begin
            errors++;
            $display("[TB] FAIL evp_end: busy=%b writes=%0d required 0/1", bus.busy, wrCount - w0);
        end
    endtask

    task automatic test_evb_multi();
        logic [15:0] words[4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        int  idx = 0;
        int  stalls = 0;
        int  w0 = wrCount;
        logic gotDone = 1'b0;
        startExec();
        checks++;
        if (bus.eng_start !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL evb_start: got %b required 0100", bus.eng_start);
        end
        tick();
        for (int k = 0; k < 30; k++) begin
            bus.out_full = (k >= 1 && k <= 3);
            bus.eng_emit = '0;
            bus.eng_done = '0;
            #1;
            if (bus.eng_hold) begin
                stalls++;
            end
            if (idx < 4 && !bus.eng_hold) begin
                bus.eng_result[32 +: 16] = words[idx];
                bus.eng_status[32 +: 16] = 16'h0A00 + 16'(idx);
                if (idx == 3) bus.eng_done[2] = 1'b1;
                else          bus.eng_emit[2] = 1'b1;
                sbQ.push_back({words[idx], 16'h0A00 + 16'(idx)});
                idx++;
            end
            tick();
            if (bus.done) begin
                gotDone = 1'b1;
                break;
            end
        end
        bus.eng_emit = '0;
        bus.eng_done = '0;
        bus.out_full = 1'b0;
        checks++;
        if (gotDone !== 1'b1) begin
            errors++;
            $display("[TB] FAIL evb_timeout: done seen=%b required 1", gotDone);
        end
        checks++;
        if (stalls != 3) begin
            errors++;
            $display("[TB] FAIL evb_hold: eng_hold cycles=%0d required 3", stalls);
        end
        checks++;
        if (wrCount - w0 != 4 || bus.err_ovf !== 1'b0) begin
            errors++;
            $display("[TB] FAIL evb_writes: writes=%0d err_ovf=%b required 4/0", wrCount - w0, bus.err_ovf);
        end
        tick();
    endtask

    task automatic test_illegal();
        int   w0 = wrCount;
        logic anyStart = 1'b0;
        logic gotDone = 1'b0;
        sbQ.push_back({16'h0000, 16'hFFFF});
        startExec();
        for (int k = 0; k < 10; k++) begin
            if (bus.eng_start != 0) anyStart = 1'b1;
            if (bus.done) begin
                gotDone = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if ({anyStart, gotDone} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL illegal: eng_start seen=%b done=%b required 0/1", anyStart, gotDone);
        end
        checks++;
        if (wrCount - w0 != 1) begin
            errors++;
            $display("[TB] FAIL illegal_writes: writes=%0d required 1", wrCount - w0);
        end
        tick();
    endtask

    task automatic test_watchdog();
        int   n = 0;
        logic gotDone = 1'b0;
        sbQ.push_back({16'h0000, 16'hFFFE});
        startExec();
        // RUN spans TIMEOUT cycles after the eng_start cycle; abort follows.
        for (int k = 0; k < 40; k++) begin
            tick();
            n++;
            if (bus.eng_abort != 0) break;
        end
        checks++;
        if (n != TO + 1 || bus.eng_abort !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL watchdog_abort: at %0d abort=%b required %0d/0010", n, bus.eng_abort, TO + 1);
        end
        tick();
        checks++;
        if (bus.eng_abort !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL watchdog_pulse: abort=%b required 0000", bus.eng_abort);
        end
        for (int k = 0; k < 10; k++) begin
            if (bus.done) begin
                gotDone = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (gotDone !== 1'b1) begin
            errors++;
            $display("[TB] FAIL watchdog_done: done seen=%b required 1", gotDone);
        end
        tick();
    endtask

    task automatic test_done_at_timeout();
        logic anyAbort = 1'b0;
        startExec();
        for (int k = 0; k < TO; k++) begin
            tick();
            if (bus.eng_abort != 0) anyAbort = 1'b1;
        end
        bus.eng_result[16 +: 16] = 16'h0BEE;
        bus.eng_status[16 +: 16] = 16'h0005;
        bus.eng_done[1]          = 1'b1;
        sbQ.push_back({16'h0BEE, 16'h0005});
        tick();
        bus.eng_done = '0;
        if (bus.eng_abort != 0) anyAbort = 1'b1;
        checks++;
        if ({anyAbort, bus.out_wr_en} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL done_priority: abort seen=%b wr=%b required 0/1", anyAbort, bus.out_wr_en);
        end
        tick();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_priority_done: done=%b required 1", bus.done);
        end
        tick();
    endtask

    task automatic test_rst_engine();
        int w0 = wrCount;
        startExec();
        checks++;
        if (bus.eng_start !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL rst_start: got %b required 1000", bus.eng_start);
        end
        repeat (3) tick();
        bus.eng_done[3] = 1'b1;
        tick();
        bus.eng_done = '0;
        checks++;
        if ({bus.done, bus.out_wr_en} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rst_done: done/wr=%b required 10", {bus.done, bus.out_wr_en});
        end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || wrCount != w0) begin
            errors++;
            $display("[TB] FAIL rst_nowrite: busy=%b writes=%0d required 0/0", bus.busy, wrCount - w0);
        end
    endtask

    task automatic test_overflow();
        int w0 = wrCount;
        startExec();
        tick();
        bus.out_full             = 1'b1;
        bus.eng_result[32 +: 16] = 16'h5A5A;
        bus.eng_status[32 +: 16] = 16'h0001;
        bus.eng_emit[2]          = 1'b1;
        sbQ.push_back({16'h5A5A, 16'h0001});
        tick();
        #1;
        checks++;
        if (bus.eng_hold !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_hold: eng_hold=%b required 1", bus.eng_hold);
        end
        bus.eng_result[32 +: 16] = 16'hDEAD;
        tick();
        bus.eng_emit = '0;
        checks++;
        if (bus.err_ovf !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ovf_flag: err_ovf=%b required 1", bus.err_ovf);
        end
        bus.out_full             = 1'b0;
        bus.eng_result[32 +: 16] = 16'h7777;
        bus.eng_status[32 +: 16] = 16'h0002;
        bus.eng_emit[2]          = 1'b1;
        bus.eng_done[2]          = 1'b1;
        sbQ.push_back({16'h7777, 16'h0002});
        tick();
        bus.eng_emit = '0;
        bus.eng_done = '0;
        tick();
        checks++;
        if ({bus.done, bus.err_ovf} !== 2'b11 || wrCount - w0 != 2) begin
            errors++;
            $display("[TB] FAIL ovf_end: done/ovf=%b writes=%0d required 11/2", {bus.done, bus.err_ovf}, wrCount - w0);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int w0;
        startExec();
        tick();
        bus.out_full    = 1'b1;
        bus.eng_emit[2] = 1'b1;
        tick();
        bus.eng_emit = '0;
        #1;
        checks++;
        if ({bus.busy, bus.eng_hold} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL midrst_setup: busy/hold=%b required 11", {bus.busy, bus.eng_hold});
        end
        w0 = wrCount;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.out_wr_en, bus.eng_hold, bus.err_ovf, bus.done, bus.eng_start,
             bus.eng_abort, bus.fetch_start, bus.arg1_q, bus.arg2_q} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL midrst_outputs: got %h required 0",
                     {bus.busy, bus.out_wr_en, bus.eng_hold, bus.err_ovf, bus.done, bus.eng_start,
                      bus.eng_abort, bus.fetch_start, bus.arg1_q, bus.arg2_q});
        end
        bus.out_full = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus.busy !== 1'b0 || wrCount != w0) begin
            errors++;
            $display("[TB] FAIL midrst_discard: busy=%b writes=%0d required 0/0", bus.busy, wrCount - w0);
        end
    endtask

    initial begin
        test_reset();
        test_fetch(8'd1, 3'd2, 5'd5);
        test_evp();
        test_fetch(8'd2, 3'd1, 5'd3);
        test_evb_multi();
        test_fetch(8'd9, 3'd4, 5'd17);
        test_illegal();
        test_fetch(8'd1, 3'd0, 5'd0);
        test_watchdog();
        test_done_at_timeout();
        test_fetch(8'd3, 3'd7, 5'd31);
        test_rst_engine();
        test_fetch(8'd2, 3'd5, 5'd9);
        test_overflow();
        test_reset_mid();
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: %0d words left, required 0", sbQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
